// File: rtl/rtc_mem_arbiter_pkg.sv
// rtl/rtc_mem_arbiter_pkg.sv - shared widths, FSM encoding and protected-address limit for the RTC memory arbiter
// Ports: none (package).
package rtc_mem_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  // Seconds, minutes and hours live at 0x0..0x2; this is the highest protected address.
  localparam int PROT_ADDR_LIMIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rtc_mem_arbiter_if.sv
// rtl/rtc_mem_arbiter_if.sv - bundle of the two requester ports and the store drive of the RTC memory arbiter
// Ports: a_*/b_* requester handshakes (req/we/addr/wdata in, gnt/rvalid/rdata out, a_err out),
//        mem_* registered store drive (addr/we/wdata out, rdata in).
// Modports: slave = arbiter side, master = requesters plus store side.
interface rtc_mem_arbiter_if
  import rtc_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_err;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rtc_rr_arbiter.sv
// rtl/rtc_rr_arbiter.sv - two-input round-robin arbiter with a last-winner flag
// Ports: clk, reset_n (async active-low); req_a, req_b requests; accept commits the current
//        grant and updates the last-winner flag; grant_a, grant_b combinational one-hot grant.
module rtc_rr_arbiter (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  output logic grant_a,
  output logic grant_b
);

  // 1 = B won last; resets to B so A takes the first tie.
  logic last_b_q;

  always_comb begin
    grant_a = req_a & (~req_b | last_b_q);
    grant_b = req_b & ~grant_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else if (accept) begin
      last_b_q <= grant_b;
    end
  end

endmodule

// File: rtl/rtc_mem_arbiter.sv
// rtl/rtc_mem_arbiter.sv - two-port round-robin arbiter onto a single synchronous RTC register store
// Ports: clk, reset_n (async active-low); bus (rtc_mem_arbiter_if.slave) carrying the port A
//        (host) and port B (timekeeper) handshakes and the registered mem_* store drive.
// Optional: RTC_ARB_WRPROTECT_EN drops port A writes to 0x0..0x2 and pulses a_err with a_gnt.
module rtc_mem_arbiter
  import rtc_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  rtc_mem_arbiter_if.slave    bus
);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic                  winner_b_q;
  logic                  is_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;

  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic                  wr_drop;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Requests are only looked at in IDLE, which keeps exactly one access in flight.
  assign accept = (state_q == ST_IDLE) & (bus.a_req | bus.b_req);

  rtc_rr_arbiter u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (bus.a_req),
    .req_b   (bus.b_req),
    .accept  (accept),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign sel_we    = grant_a ? bus.a_we    : bus.b_we;
  assign sel_addr  = grant_a ? bus.a_addr  : bus.b_addr;
  assign sel_wdata = grant_a ? bus.a_wdata : bus.b_wdata;

`ifdef RTC_ARB_WRPROTECT_EN
  localparam logic [ADDR_WIDTH-1:0] PROT_LIMIT = ADDR_WIDTH'(PROT_ADDR_LIMIT);
  logic prot_q;

  assign wr_drop = grant_a & bus.a_we & (bus.a_addr <= PROT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prot_q <= 1'b0;
    end else if (accept) begin
      prot_q <= wr_drop;
    end else if (state_q == ST_ISSUE) begin
      prot_q <= 1'b0;
    end
  end

  // A dropped write is still granted; the error rides alongside that grant.
  assign bus.a_err = (state_q == ST_ISSUE) & prot_q;
`else
  assign wr_drop   = 1'b0;
  assign bus.a_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      winner_b_q  <= 1'b1;
      is_write_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            winner_b_q  <= grant_b;
            is_write_q  <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we & ~wr_drop;
          end
        end
        ST_ISSUE: begin
          // The store samples the write at the end of ISSUE; never hold it longer.
          mem_we_q <= 1'b0;
        end
        ST_WAIT: begin
          if (winner_b_q) begin
            b_rdata_q <= bus.mem_rdata;
          end else begin
            a_rdata_q <= bus.mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = is_write_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.a_gnt     = (state_q == ST_ISSUE) & ~winner_b_q;
  assign bus.b_gnt     = (state_q == ST_ISSUE) &  winner_b_q;
  assign bus.a_rvalid  = (state_q == ST_RESP)  & ~winner_b_q;
  assign bus.b_rvalid  = (state_q == ST_RESP)  &  winner_b_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rtc_mem_arbiter.sv
// tb/tb_rtc_mem_arbiter.sv - self-checking bench for rtc_mem_arbiter (vector table plus read-data scoreboard)
// Ports: none (top-level bench). Honours RTC_ARB_WRPROTECT_EN when defined for the build.
module tb_rtc_mem_arbiter;
  import rtc_mem_arbiter_pkg::*;

`ifdef RTC_ARB_WRPROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    bit         port;       // 0 = A, 1 = B
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] store [16];
  vec_t vecs [16];

  rtc_mem_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rtc_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // 16x8 synchronous store: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (bus.mem_we) store[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= store[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every rvalid pops the data expected when that read was granted.
  always @(negedge clk) begin
    check("gnt_exclusive", {31'd0, bus.a_gnt & bus.b_gnt}, 0);
    if (bus.mem_we) check("mem_we_only_in_issue", {31'd0, bus.a_gnt | bus.b_gnt}, 1);
    if (bus.a_rvalid) begin
      if (qa.size() == 0) check("a_rvalid_unexpected", 1, 0);
      else check("a_rdata", {24'd0, bus.a_rdata}, {24'd0, qa.pop_front()});
    end
    if (bus.b_rvalid) begin
      if (qb.size() == 0) check("b_rvalid_unexpected", 1, 0);
      else check("b_rdata", {24'd0, bus.b_rdata}, {24'd0, qb.pop_front()});
    end
  end

  task automatic drive(input bit port, input bit req, input bit we, input logic [3:0] addr,
                       input logic [7:0] wdata);
    if (port) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  function automatic logic rv(input bit port);
    return port ? bus.b_rvalid : bus.a_rvalid;
  endfunction

  task automatic access(input int idx, input vec_t v);
    int waited;
    bit got;
    waited = 0;
    got = 0;
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (!got && waited < 12) begin
      @(negedge clk);
      waited++;
      got = v.port ? bus.b_gnt : bus.a_gnt;
    end
    check($sformatf("v%0d_gnt_seen", idx), {31'd0, got}, 1);
    check($sformatf("v%0d_gnt_latency", idx), waited, 2);
    check($sformatf("v%0d_loser_gnt", idx), {31'd0, v.port ? bus.a_gnt : bus.b_gnt}, 0);
    check($sformatf("v%0d_a_err", idx), {31'd0, bus.a_err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_mem_addr", idx), {28'd0, bus.mem_addr}, {28'd0, v.addr});
    check($sformatf("v%0d_mem_we", idx), {31'd0, bus.mem_we}, {31'd0, v.we & ~v.exp_err});
    drive(v.port, 1'b0, 1'b0, 4'h0, 8'h00);
    if (v.we) begin
      check($sformatf("v%0d_mem_wdata", idx), {24'd0, bus.mem_wdata}, {24'd0, v.wdata});
      @(negedge clk);
      check($sformatf("v%0d_mem_we_clear", idx), {31'd0, bus.mem_we}, 0);
    end else begin
      if (v.port) qb.push_back(v.exp_rdata); else qa.push_back(v.exp_rdata);
      @(negedge clk);
      check($sformatf("v%0d_rvalid_early", idx), {31'd0, rv(v.port)}, 0);
      @(negedge clk);
      check($sformatf("v%0d_rvalid", idx), {31'd0, rv(v.port)}, 1);
    end
  endtask

  initial begin
    int ga, gb, n, last_c;
    bit last_port, p;
    bit got;
    int waited;

    clk = 1'b0;
    reset_n = 1'b0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) store[i] = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    vecs[0]  = '{1'b0, 1'b1, 4'h7, 8'h5A, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 8'h5A};
    vecs[2]  = '{1'b1, 1'b1, 4'h1, 8'h33, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, 8'hFF, PROT, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b0, PROT ? 8'h33 : 8'hFF};
    vecs[5]  = '{1'b0, 1'b1, 4'h3, 8'hC3, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 4'h3, 8'h00, 1'b0, 8'hC3};
    vecs[7]  = '{1'b0, 1'b1, 4'h0, 8'h11, PROT, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 4'h2, 8'h22, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 4'h2, 8'h99, PROT, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 4'h2, 8'h00, 1'b0, PROT ? 8'h22 : 8'h99};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, PROT ? 8'h00 : 8'h11};
    vecs[12] = '{1'b1, 1'b1, 4'hF, 8'hA5, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 4'hF, 8'h00, 1'b0, 8'hA5};
    vecs[14] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'hC3};
    vecs[15] = '{1'b0, 1'b0, 4'h7, 8'h00, 1'b0, 8'h5A};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_a_gnt", {31'd0, bus.a_gnt}, 0);
    check("rst_b_gnt", {31'd0, bus.b_gnt}, 0);
    check("rst_a_rvalid", {31'd0, bus.a_rvalid}, 0);
    check("rst_b_rvalid", {31'd0, bus.b_rvalid}, 0);
    check("rst_a_err", {31'd0, bus.a_err}, 0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 0);
    check("rst_mem_addr", {28'd0, bus.mem_addr}, 0);
    check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 0);
    check("rst_a_rdata", {24'd0, bus.a_rdata}, 0);
    check("rst_b_rdata", {24'd0, bus.b_rdata}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) access(i, vecs[i]);
    check("a_rdata_held", {24'd0, bus.a_rdata}, 32'h5A);

    // Reset during the WAIT cycle of a port A read aborts it
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'h7, 8'h00);
    got = 0;
    waited = 0;
    while (!got && waited < 12) begin
      @(negedge clk);
      waited++;
      got = bus.a_gnt;
    end
    check("abort_gnt_latency", waited, 2);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_a_rdata_in_reset", {24'd0, bus.a_rdata}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rvalid", {31'd0, bus.a_rvalid}, 0);
    end
    check("abort_a_rdata", {24'd0, bus.a_rdata}, 0);

    // First tie after reset goes to A; B follows in the IDLE cycle after A's RESP
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'h7, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
    ga = 0;
    gb = 0;
    for (int c = 1; c <= 20 && gb == 0; c++) begin
      @(negedge clk);
      if (bus.a_gnt && ga == 0) begin
        ga = c; qa.push_back(8'h5A); drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      end
      if (bus.b_gnt) begin
        gb = c; qb.push_back(8'hA5); drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    check("tie_a_first", ga, 2);
    check("tie_b_second", gb, 6);
    repeat (3) @(negedge clk);

    // Both held requesting reads: grants alternate, one every 4 cycles
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'h7, 8'h00);
    n = 0;
    last_c = 0;
    last_port = 1'b0;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      @(negedge clk);
      if (bus.a_gnt || bus.b_gnt) begin
        p = bus.b_gnt;
        if (p) qb.push_back(8'h5A); else qa.push_back(8'hC3);
        if (n == 0) check("alt_first_is_a", {31'd0, p}, 0);
        else begin
          check("alt_port", {31'd0, p}, {31'd0, ~last_port});
          check("alt_spacing", c - last_c, 4);
        end
        last_port = p;
        last_c = c;
        n++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    check("alt_count", n, 6);
    repeat (4) @(negedge clk);

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_mem_arbiter.md
RTC_MEM_ARBITER -- requirements
Module: rtc_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of memory word and all data ports.
REQ-002 Parameter ADDR_WIDTH, default 4: width of all address ports (16 locations).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 a_req, a_we  input  1 each  port A (host/configuration) request and write flag.
REQ-006 a_addr  input  ADDR_WIDTH, a_wdata  input  DATA_WIDTH  port A address and write data.
REQ-007 a_gnt  output  1  one-cycle accept pulse. a_rvalid  output  1  one-cycle read-data-valid pulse. a_rdata  output  DATA_WIDTH  read data.
REQ-008 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (timekeeper), identical widths and meanings to port A.
REQ-009 mem_addr  output  ADDR_WIDTH, mem_we  output  1, mem_wdata  output  DATA_WIDTH  registered drive to the 16x8 synchronous store.
REQ-010 mem_rdata  input  DATA_WIDTH  store output; valid the cycle after the store samples mem_we=0.
REQ-011 a_err  output  1  one-cycle pulse on a dropped protected write (macro only; tied 0 otherwise).

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one access in flight.
REQ-013 IDLE, any req high at edge N: latch winner's we/addr/wdata into mem_*; pulse winner gnt in cycle N+1; go to ISSUE.
REQ-014 ISSUE (cycle N+1): mem_* held; write -> back to IDLE, store written at end of N+1, mem_we returns 0 in N+2; read -> WAIT.
REQ-015 WAIT (cycle N+2): register mem_rdata into winner's rdata; go to RESP.
REQ-016 RESP (cycle N+3): winner rvalid=1 for exactly one cycle; rdata holds until that port's next read; go to IDLE.
REQ-017 Throughput: write every 2 cycles, read every 4 cycles; new request is sampled only in IDLE.
REQ-018 Requester holds req/we/addr/wdata stable until its gnt; deasserts or presents next request the cycle after gnt.
REQ-019 Arbitration round-robin: sole requester wins; both requesting -> port not granted last wins.
REQ-020 Last-winner flag resets to B, so A wins the first tie.
REQ-021 mem_we is 1 only in ISSUE for a write; 0 in all other states.
REQ-022 gnt and rvalid never assert for the losing port; a_gnt and b_gnt never assert together.
REQ-023 Address wrap is not applicable; all 2^ADDR_WIDTH addresses are legal.

Reset
REQ-024 reset_n low: state=IDLE, all gnt/rvalid/err=0, mem_we=0, mem_addr=0, mem_wdata=0, a_rdata=b_rdata=0, last-winner=B.
REQ-025 Reset asserted mid-access aborts it: no gnt, rvalid or err afterwards; an ISSUE-cycle write is not guaranteed to complete.

Configuration
REQ-026 Macro RTC_ARB_WRPROTECT_EN defined: port A writes to addresses 0x0-0x2 (seconds, minutes, hours) are granted but forced mem_we=0, a_err pulses with a_gnt, FSM returns to IDLE from ISSUE, no rvalid.
REQ-027 Macro undefined: no protection; a_err tied 0; port A writes any address.

Structure
REQ-028 Shared package holds DATA_WIDTH/ADDR_WIDTH defaults, FSM state encoding and protected-address limit constant (0x2).
REQ-029 Sub-module rtc_rr_arbiter (two-input round-robin, last-winner flag) is instantiated; FSM and datapath stay in top.

Verification
REQ-030 A write 0x5A to 0x7 at N -> a_gnt in N+1, mem_we=1 addr=0x7 in N+1; B read 0x7 -> b_rvalid 3 cycles after its grant edge, b_rdata=0x5A.
REQ-031 A and B both read from IDLE after reset -> A granted first, B granted in the IDLE cycle after A's RESP.
REQ-032 Both held requesting continuously, reads -> grants strictly alternate A,B,A,B; one gnt per 4 cycles.
REQ-033 reset_n low during WAIT of an A read -> no a_rvalid, a_rdata=0, state IDLE after release.
REQ-034 With RTC_ARB_WRPROTECT_EN: A write 0xFF to 0x1 -> a_gnt and a_err same cycle, mem_we stays 0, B read 0x1 returns prior value; A write to 0x3 succeeds with a_err=0.
REQ-035 Without macro: same A write to 0x1 -> a_err=0, B read 0x1 returns 0xFF.
